// File: rtl/isa_pkg.sv
// ============================================================================
//  Module      : isa_pkg
//  Description : Opcode and instruction-format definitions for the 16-bit ISA,
//                shared by the decode path and the boot-time encoder/loader.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package isa_pkg;

    localparam int c_WORD_W = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_BEQ = 4'h2,
        OP_BGT = 4'h3,
        OP_BLT = 4'h4,
        OP_B   = 4'h5,
        OP_MOV = 4'h6,
        OP_LDR = 4'h7,
        OP_LSL = 4'h8,
        OP_STR = 4'h9,
        OP_NEG = 4'hA
    } opcode_t;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_J   = 2'd1,
        FMT_I   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_t;

    // Opcodes 0xB..0xF have no enum member and fall through to FMT_BAD.
    function automatic fmt_t op_fmt(input opcode_t op);
        fmt_t f;
        case (op)
            OP_ADD, OP_SUB, OP_NEG:         f = FMT_R;
            OP_BEQ, OP_BGT, OP_BLT, OP_B:   f = FMT_J;
            OP_MOV, OP_LDR, OP_LSL, OP_STR: f = FMT_I;
            default:                        f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_packer.sv
// ============================================================================
//  Module      : instr_field_packer
//  Description : Combinational packing of decoded fields into one 16-bit word.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_field_packer
    import isa_pkg::*;
(
    input  logic [3:0]          op,
    input  logic [3:0]          rd,
    input  logic [3:0]          rs1,
    input  logic [3:0]          rs2,
    input  logic [11:0]         imm,
    output logic [c_WORD_W-1:0] word,
    output logic                illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_fmt(opcode_t'(op)))
            FMT_R:   word = {op, rd, rs1, rs2};
            FMT_J:   word = {op, imm};
            FMT_I:   word = {op, rd, imm[7:0]};
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Boot loader that encodes streamed field sets into instruction
//                memory from address 0 and holds the CPU until loading ends.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [3:0]          in_op,
    input  logic [3:0]          in_rd,
    input  logic [3:0]          in_rs1,
    input  logic [3:0]          in_rs2,
    input  logic [11:0]         in_imm,
    output logic                imem_we,
    output logic [AW-1:0]       imem_addr,
    output logic [c_WORD_W-1:0] imem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                err_illegal,
    output logic                err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_wr_ptr;
    logic                  r_we;
    logic [AW-1:0]         r_addr;
    logic [c_WORD_W-1:0]   r_wdata;
    logic                  r_err_illegal;
    logic                  r_err_overflow;
    logic [c_WORD_W-1:0]   w_word;
    logic                  w_illegal;
    logic                  w_hs;
    logic                  w_full;
    logic                  w_start_load;

    instr_field_packer u_packer (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    assign w_hs   = in_valid & in_ready;
    assign w_full = (r_wr_ptr == AW'(DEPTH - 1));

    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_LOAD;
                    w_start_load = 1'b1;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                // A legal word landing in the top slot ends the load even without in_last.
                if (in_valid && (in_last || (!w_illegal && w_full))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) begin
                    w_state_nxt  = S_LOAD;
                    w_start_load = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= 1'b0;
            if (w_start_load) begin
                r_wr_ptr       <= '0;
                r_err_illegal  <= 1'b0;
                r_err_overflow <= 1'b0;
            end else if (w_hs) begin
                if (w_illegal) begin
                    r_err_illegal <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_wr_ptr;
                    r_wdata <= w_word;
                    // Pointer saturates at the top slot rather than wrapping.
                    if (!w_full) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end else if (!in_last) begin
                        r_err_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign err_illegal  = r_err_illegal;
    assign err_overflow = r_err_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Self-checking bench: directed vector table, corner sequences
//                and random programs against an arithmetic encoding model.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_encoder_loader;

    localparam int c_DEPTH = 16;
    localparam int c_AW    = 4;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_last;
    logic [3:0]       in_op, in_rd, in_rs1, in_rs2;
    logic [11:0]      in_imm;
    logic             in_ready, imem_we, cpu_hold, done, err_illegal, err_overflow;
    logic [c_AW-1:0]  imem_addr;
    logic [15:0]      imem_wdata;
    logic             in_ready4, imem_we4, cpu_hold4, done4, err_illegal4, err_overflow4;
    logic [1:0]       imem_addr4;
    logic [15:0]      imem_wdata4;

    int checks = 0;
    int errors = 0;
    int wa[$];
    int wd[$];
    int w4a[$];
    int w4d[$];

    typedef struct {
        int op; int rd; int rs1; int rs2; int imm;
        bit last; bit we; int addr; int word;
    } vec_t;
    vec_t tbl[8];

    instr_encoder_loader #(.DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    instr_encoder_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .cpu_hold(cpu_hold4), .done(done4), .err_illegal(err_illegal4), .err_overflow(err_overflow4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(int'(imem_wdata));
        end
        if (imem_we4 === 1'b1) begin
            w4a.push_back(int'(imem_addr4));
            w4d.push_back(int'(imem_wdata4));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Encoding as place-value arithmetic: op in the top nibble, then fields.
    function automatic int enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
        if (op == 0 || op == 1 || op == 10) return op * 4096 + rd * 256 + rs1 * 16 + rs2;
        if (op >= 2 && op <= 5)             return op * 4096 + imm;
        if (op >= 6 && op <= 9)             return op * 4096 + rd * 256 + (imm % 256);
        return -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Presents one field set; returns at #1 after the accepting edge (cycle N+1).
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input bit lst, output int cyc);
        bit rdy;
        in_valid = 1'b1;
        in_op    = 4'(op);
        in_rd    = 4'(rd);
        in_rs1   = 4'(rs1);
        in_rs2   = 4'(rs2);
        in_imm   = 12'(imm);
        in_last  = lst;
        cyc      = -1;
        for (int k = 1; k <= 20; k++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                cyc = k;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: no handshake in 20 cycles, got 0 required 1");
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

        tbl[0] = '{4'h0, 1, 2, 3, 'h000, 1'b0, 1'b1, 0, 'h0123};
        tbl[1] = '{4'h6, 4, 0, 0, 'hFA5, 1'b0, 1'b1, 1, 'h64A5};
        tbl[2] = '{4'hC, 1, 1, 1, 'h111, 1'b0, 1'b0, 2, 0};
        tbl[3] = '{4'h1, 'hF, 'hE, 'hD, 'h000, 1'b0, 1'b1, 2, 'h1FED};
        tbl[4] = '{4'hA, 'hA, 0, 5, 'h000, 1'b0, 1'b1, 3, 'hAA05};
        tbl[5] = '{4'h7, 3, 9, 9, 'h712, 1'b0, 1'b1, 4, 'h7312};
        tbl[6] = '{4'h2, 5, 5, 5, 'h800, 1'b0, 1'b1, 5, 'h2800};
        tbl[7] = '{4'h5, 0, 0, 0, 'hFFE, 1'b1, 1'b1, 6, 'h5FFE};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_we", int'(imem_we), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_wdata", int'(imem_wdata), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_err_illegal", int'(err_illegal), 0);
        chk("rst_err_overflow", int'(err_overflow), 0);

        // Idle without start must not accept anything.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_ready", int'(in_ready), 0);
        chk("idle_no_we", int'(imem_we), 0);
        in_valid = 1'b0;

        // Directed vector table: one program including an illegal opcode.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].last, cyc);
            chk($sformatf("vec%0d_we", i), int'(imem_we), int'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("vec%0d_addr", i), int'(imem_addr), tbl[i].addr);
                chk($sformatf("vec%0d_wdata", i), int'(imem_wdata), tbl[i].word);
            end
            chk($sformatf("vec%0d_cpu_hold", i), int'(cpu_hold), tbl[i].last ? 0 : 1);
            chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].last));
        end
        chk("vec_err_illegal", int'(err_illegal), 1);
        chk("vec_err_overflow", int'(err_overflow), 0);
        chk("vec_ready_after_done", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("vec_we_single_cycle", int'(imem_we), 0);
        chk("vec_addr_hold", int'(imem_addr), 6);
        chk("vec_wdata_hold", int'(imem_wdata), 'h5FFE);

        // Reload from DONE clears errors and re-holds the CPU.
        pulse_start();
        chk("reload_err_cleared", int'(err_illegal), 0);
        chk("reload_cpu_hold", int'(cpu_hold), 1);

        // Reset asserted the cycle after a handshake.
        send(0, 1, 2, 3, 0, 1'b0, cyc);
        send(1, 2, 3, 4, 0, 1'b0, cyc);
        chk("rstmid_pre_addr", int'(imem_addr), 1);
        do_reset();
        chk("rstmid_we", int'(imem_we), 0);
        chk("rstmid_addr", int'(imem_addr), 0);
        chk("rstmid_cpu_hold", int'(cpu_hold), 1);
        chk("rstmid_in_ready", int'(in_ready), 0);

        // Reset coinciding with a handshake discards the pending write.
        pulse_start();
        in_valid = 1'b1; in_op = 4'h0; in_rd = 4'h7; in_rs1 = 4'h7; in_rs2 = 4'h7;
        do_reset();
        in_valid = 1'b0;
        chk("rstpend_we", int'(imem_we), 0);
        chk("rstpend_in_ready", int'(in_ready), 0);
        pulse_start();
        send(1, 1, 1, 1, 0, 1'b0, cyc);
        chk("reload_addr0", int'(imem_addr), 0);
        chk("reload_wdata", int'(imem_wdata), 'h1111);

        // Eight back-to-back words with a start pulse ignored mid-load.
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) start = 1'b1;
            send(0, i, i, 15 - i, 0, i == 7, cyc);
            start = 1'b0;
            chk($sformatf("b2b%0d_latency", i), cyc, 1);
            chk($sformatf("b2b%0d_we", i), int'(imem_we), 1);
            chk($sformatf("b2b%0d_addr", i), int'(imem_addr), i);
        end
        chk("b2b_done", int'(done), 1);

        // Small-memory instance fills without in_last.
        do_reset();
        w4a.delete(); w4d.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send(6, i, 0, 0, i, 1'b0, cyc);
        @(posedge clk); #1;
        chk("ovf_writes", w4a.size(), 4);
        for (int i = 0; i < 4 && i < w4a.size(); i++) begin
            chk($sformatf("ovf_addr%0d", i), w4a[i], i);
            chk($sformatf("ovf_wdata%0d", i), w4d[i], 'h6000 + i * 256 + i);
        end
        chk("ovf_done", int'(done4), 1);
        chk("ovf_flag", int'(err_overflow4), 1);
        chk("ovf_in_ready", int'(in_ready4), 0);
        chk("ovf_cpu_hold", int'(cpu_hold4), 0);
        chk("ovf_big_flag", int'(err_overflow), 0);

        // Random programs against the encoding model.
        do_reset();
        for (int p = 0; p < 40; p++) begin
            int n, endi;
            bit ill, ovf;
            int ops[24], rds[24], r1s[24], r2s[24], ims[24];
            int ew[$];
            n = $urandom_range(1, 24);
            endi = n - 1; ill = 1'b0; ovf = 1'b0;
            ew.delete();
            for (int i = 0; i < n; i++) begin
                ops[i] = $urandom_range(0, 15);
                rds[i] = $urandom_range(0, 15);
                r1s[i] = $urandom_range(0, 15);
                r2s[i] = $urandom_range(0, 15);
                ims[i] = $urandom_range(0, 4095);
            end
            for (int i = 0; i < n; i++) begin
                int w;
                w = enc(ops[i], rds[i], r1s[i], r2s[i], ims[i]);
                if (w < 0) ill = 1'b1;
                else begin
                    ew.push_back(w);
                    if (ew.size() == c_DEPTH && i != n - 1) begin
                        endi = i;
                        ovf = 1'b1;
                        break;
                    end
                end
            end
            wa.delete(); wd.delete();
            pulse_start();
            for (int i = 0; i <= endi; i++) begin
                repeat ($urandom_range(0, 3) / 2) @(posedge clk);
                #1;
                send(ops[i], rds[i], r1s[i], r2s[i], ims[i], i == n - 1, cyc);
            end
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_done", p), int'(done), 1);
            chk($sformatf("rnd%0d_in_ready", p), int'(in_ready), 0);
            chk($sformatf("rnd%0d_cpu_hold", p), int'(cpu_hold), 0);
            chk($sformatf("rnd%0d_err_illegal", p), int'(err_illegal), int'(ill));
            chk($sformatf("rnd%0d_err_overflow", p), int'(err_overflow), int'(ovf));
            chk($sformatf("rnd%0d_nwrites", p), wa.size(), ew.size());
            for (int j = 0; j < ew.size() && j < wa.size(); j++) begin
                chk($sformatf("rnd%0d_addr%0d", p, j), wa[j], j);
                chk($sformatf("rnd%0d_wdata%0d", p, j), wd[j], ew[j]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
